// File: rtl/devc_pkg.sv
// Shared types and constants for the Device C handshake transmitter.
package devc_pkg;

    localparam int DEVC_DATA_W_DEFAULT = 8;
    localparam int DEVC_CNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } devc_state_t;

endpackage

// File: rtl/devc_cycle_counter.sv
// Loadable down-counter with enable and zero flag.
// Load has priority over enable; the count holds at zero rather than wrapping.
module devc_cycle_counter
    import devc_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DEVC_CNT_W-1:0] loadValue_i,
    input  logic                  enable_i,
    output logic                  zero_o
);

    logic [DEVC_CNT_W-1:0] count_q;

    // Count register: reload on request, otherwise count down toward zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadValue_i;
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/devc_handshake_tx.sv
// Device C transmitter for the readyC/acceptedD handshake.
// Takes one byte from upstream, offers it to Device D on data_C/readyC
// until acceptedD, then waits GAP_CYCLES idle cycles before the next byte.
// Optional REQ timeout is built only when DEVC_TIMEOUT_EN is defined.
module devc_handshake_tx
    import devc_pkg::*;
#(
    parameter int DATA_W         = DEVC_DATA_W_DEFAULT,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  src_valid,
    input  logic [DATA_W-1:0]     src_data,
    output logic                  src_ready,
    output logic                  readyC,
    output logic [DATA_W-1:0]     data_C,
    input  logic                  acceptedD,
    output logic                  busy,
    output logic [DEVC_CNT_W-1:0] sent_count,
    output logic                  proto_err,
    output logic                  timeout
);

    localparam logic [DEVC_CNT_W-1:0] GAP_LOAD = DEVC_CNT_W'(GAP_CYCLES - 1);

    devc_state_t           state_q;
    logic                  readyC_q;
    logic [DATA_W-1:0]     dataC_q;
    logic                  busy_q;
    logic [DEVC_CNT_W-1:0] sentCount_q;
    logic                  protoErr_q;
    logic                  gapZero;
    logic                  reqExpired;

    // Gap counter: loaded as a transfer completes, counts down through GAP.
    devc_cycle_counter u_gapCounter (
        .clock       (clock),
        .reset       (reset),
        .load_i      ((state_q == REQ) && acceptedD),
        .loadValue_i (GAP_LOAD),
        .enable_i    (state_q == GAP),
        .zero_o      (gapZero)
    );

`ifdef DEVC_TIMEOUT_EN
    localparam logic [DEVC_CNT_W-1:0] TIMEOUT_LOAD = DEVC_CNT_W'(TIMEOUT_CYCLES - 1);

    logic reqZero;

    // REQ watchdog: armed on REQ entry, reaches zero on the last allowed REQ cycle.
    devc_cycle_counter u_reqCounter (
        .clock       (clock),
        .reset       (reset),
        .load_i      ((state_q == IDLE) && src_valid),
        .loadValue_i (TIMEOUT_LOAD),
        .enable_i    (state_q == REQ),
        .zero_o      (reqZero)
    );

    assign reqExpired = (state_q == REQ) && reqZero;
    assign timeout    = reqExpired && !acceptedD;
`else
    logic [7:0] unusedTimeoutCfg;

    assign unusedTimeoutCfg = 8'(TIMEOUT_CYCLES);
    assign reqExpired       = 1'b0;
    assign timeout          = 1'b0;
`endif

    // Handshake FSM with registered readyC, data_C, busy, count and error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            readyC_q    <= 1'b0;
            dataC_q     <= '0;
            busy_q      <= 1'b0;
            sentCount_q <= '0;
            protoErr_q  <= 1'b0;
        end else begin
            if (acceptedD && (state_q != REQ)) begin
                protoErr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (src_valid) begin
                        dataC_q  <= src_data;
                        state_q  <= REQ;
                        readyC_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (acceptedD) begin
                        state_q     <= GAP;
                        readyC_q    <= 1'b0;
                        sentCount_q <= sentCount_q + 1'b1;
                    end else if (reqExpired) begin
                        state_q  <= IDLE;
                        readyC_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                GAP: begin
                    if (gapZero) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    readyC_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready  = (state_q == IDLE);
    assign readyC     = readyC_q;
    assign data_C     = dataC_q;
    assign busy       = busy_q;
    assign sent_count = sentCount_q;
    assign proto_err  = protoErr_q;

endmodule

// File: tb/tb_devc_handshake_tx.sv
// Self-checking bench for devc_handshake_tx: directed scenarios followed by
// random traffic, all compared cycle by cycle against a transaction-level model.
module tb_devc_handshake_tx;

    localparam int TB_GAP     = 2;
    localparam int TB_TIMEOUT = 4;

    logic       clock;
    logic       reset;
    logic       srcValid;
    logic [7:0] srcData;
    logic       srcReady;
    logic       readyC;
    logic [7:0] dataC;
    logic       acceptedD;
    logic       busy;
    logic [7:0] sentCount;
    logic       protoErr;
    logic       timeout;

    int checks;
    int errors;

    // Model: phase 0 = waiting for upstream, 1 = offering, 2 = cooling down.
    int         mPhase;
    logic [7:0] mHeld;
    int         mCoolLeft;
    int         mWaited;
    int         mSent;
    logic       mErr;

    devc_handshake_tx #(
        .DATA_W         (8),
        .GAP_CYCLES     (TB_GAP),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .src_valid  (srcValid),
        .src_data   (srcData),
        .src_ready  (srcReady),
        .readyC     (readyC),
        .data_C     (dataC),
        .acceptedD  (acceptedD),
        .busy       (busy),
        .sent_count (sentCount),
        .proto_err  (protoErr),
        .timeout    (timeout)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase    = 0;
        mHeld     = 8'h00;
        mCoolLeft = 0;
        mWaited   = 0;
        mSent     = 0;
        mErr      = 1'b0;
    endtask

    function automatic logic modelTimeout(input logic a);
`ifdef DEVC_TIMEOUT_EN
        return (mPhase == 1) && (mWaited == TB_TIMEOUT) && !a;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelStep(input logic v, input logic [7:0] d, input logic a);
        logic expired;
        expired = modelTimeout(a);
        if (a && (mPhase != 1)) mErr = 1'b1;
        if (mPhase == 0) begin
            if (v) begin
                mHeld   = d;
                mPhase  = 1;
                mWaited = 1;
            end
        end else if (mPhase == 1) begin
            if (a) begin
                mPhase    = 2;
                mCoolLeft = TB_GAP;
                mSent     = mSent + 1;
            end else if (expired) begin
                mPhase = 0;
            end else begin
                mWaited = mWaited + 1;
            end
        end else begin
            mCoolLeft = mCoolLeft - 1;
            if (mCoolLeft == 0) mPhase = 0;
        end
    endtask

    // One clock cycle: drive inputs, compare every output, advance the model.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic a);
        @(negedge clock);
        srcValid  = v;
        srcData   = d;
        acceptedD = a;
        #1;
        checkOutput("src_ready", 32'(srcReady), 32'(mPhase == 0));
        checkOutput("readyC", 32'(readyC), 32'(mPhase == 1));
        checkOutput("busy", 32'(busy), 32'(mPhase != 0));
        checkOutput("data_C", 32'(dataC), 32'(mHeld));
        checkOutput("sent_count", 32'(sentCount), 32'(mSent % 256));
        checkOutput("proto_err", 32'(protoErr), 32'(mErr));
        checkOutput("timeout", 32'(timeout), 32'(modelTimeout(a)));
        modelStep(v, d, a);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic applyReset();
        @(negedge clock);
        reset     = 1'b1;
        srcValid  = 1'b0;
        acceptedD = 1'b0;
        #1;
        checkOutput("rst_readyC", 32'(readyC), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_src_ready", 32'(srcReady), 32'd1);
        checkOutput("rst_sent_count", 32'(sentCount), 32'd0);
        modelReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        srcValid  = 1'b0;
        srcData   = 8'h00;
        acceptedD = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        applyReset();

        // Basic transfer of A5, receiver acknowledges on its second readyC cycle.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);

        // Back-to-back with src_valid held high.
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);

`ifndef DEVC_TIMEOUT_EN
        // Stalled receiver: ten cycles without acceptedD, then acknowledge.
        applyStimulus(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
`else
        // Watchdog expiry, then acknowledge arriving on the expiry cycle.
        applyStimulus(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
`endif

        // Spurious acknowledge while idle; flag must stick.
        applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);

        // Reset while offering a byte.
        applyStimulus(1'b1, 8'hC3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyReset();
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Random traffic with occasional spurious acks and resets.
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic a;
            v = ($urandom_range(0, 1) == 1);
            if (mPhase == 1) a = ($urandom_range(0, 3) == 0);
            else             a = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 249) == 0) applyReset();
            else applyStimulus(v, 8'($urandom_range(0, 255)), a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
